// File: rtl/dm_responder.sv
`default_nettype none
// ============================================================================
// Module   : dm_responder
// Purpose  : Data-memory responder for the pipeline load/store port.
//            Request/ready/done handshake, byte-enabled stores, programmable
//            wait states, misaligned / out-of-range address reporting.
// Revision : 1.0 - initial release
// ============================================================================
module dm_responder #(
   parameter int NMEM    = 128,  // memory depth in 32-bit words
   parameter int LATENCY = 2     // wait states between accept and completion (0..15)
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_i,
   input  logic        we_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   input  logic [3:0]  be_i,
   output logic        ready_o,
   output logic        done_o,
   output logic [31:0] rdata_o,
   output logic        err_o
);

   localparam int AW = (NMEM > 1) ? $clog2(NMEM) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t        state_q;
   logic [3:0]    cnt_q;
   logic          pend_q;     // a latched transaction is waiting for its access edge
   logic          ready_q;
   logic          done_q;
   logic [31:0]   rdata_q;
   logic          err_q;

   logic          we_q;
   logic [31:0]   addr_q;
   logic [31:0]   wdata_q;
   logic [3:0]    be_q;

   logic [31:0]   mem_q [NMEM];

   logic          accept_d;
   logic          access_d;
   logic          addr_err_d;
   logic [AW-1:0] idx_d;

   // Handshake decode and address checks on the latched request
   always_comb begin
      accept_d   = req_i & ready_q;
      // The counter holds the number of wait edges still to pass before the
      // access edge; with no wait states the access follows the accept edge.
      access_d   = pend_q & ((state_q != BUSY) | (cnt_q == 4'd0));
      addr_err_d = (addr_q[1:0] != 2'b00) | (addr_q >= 32'(4 * NMEM));
      idx_d      = addr_q[AW+1:2];
   end

   // Control FSM with registered handshake and response outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         pend_q  <= 1'b0;
         ready_q <= 1'b1;
         done_q  <= 1'b0;
         rdata_q <= 32'd0;
         err_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= 32'd0;
         wdata_q <= 32'd0;
         be_q    <= 4'd0;
      end else begin
         done_q <= access_d;

         // Completion of the pending access updates the response registers
         if (access_d) begin
            if (addr_err_d) begin
               rdata_q <= 32'd0;
               err_q   <= 1'b1;
            end else begin
               err_q <= 1'b0;
               if (!we_q) begin
                  rdata_q <= mem_q[idx_d];
               end
            end
         end

         if (accept_d) begin
            we_q    <= we_i;
            addr_q  <= addr_i;
            wdata_q <= wdata_i;
            be_q    <= be_i;
            pend_q  <= 1'b1;
            if (LATENCY > 0) begin
               state_q <= BUSY;
               cnt_q   <= 4'(LATENCY);
               ready_q <= 1'b0;
            end else begin
               // Zero wait states: stay ready so a new request can overlap
               // the access of the previous one.
               state_q <= RESP;
               ready_q <= 1'b1;
            end
         end else if (access_d) begin
            pend_q  <= 1'b0;
            state_q <= RESP;
            ready_q <= 1'b1;
         end else if (state_q == RESP) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
         end else if (state_q == BUSY) begin
            cnt_q <= cnt_q - 4'd1;
         end
      end
   end

   // Byte-lane store into the word array; contents survive reset
   always_ff @(posedge clk) begin
      if (access_d && we_q && !addr_err_d) begin
         for (int i = 0; i < 4; i++) begin
            if (be_q[i]) begin
               mem_q[idx_d][8*i +: 8] <= wdata_q[8*i +: 8];
            end
         end
      end
   end

   assign ready_o = ready_q;
   assign done_o  = done_q;
   assign rdata_o = rdata_q;
   assign err_o   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_dm_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_dm_responder
// Purpose  : Randomized scoreboard bench for dm_responder. One instance runs
//            with two wait states, another with none; a word-array reference
//            model predicts every completion and its cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dm_responder;

   localparam int NMEM = 128;

   logic        clk;
   logic        rst_n;
   logic        req   [2];
   logic        we    [2];
   logic [31:0] addr  [2];
   logic [31:0] wdata [2];
   logic [3:0]  be    [2];
   logic        ready [2];
   logic        done  [2];
   logic [31:0] rdata [2];
   logic        err   [2];

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   typedef struct {
      int          inst;
      logic [31:0] rd;
      logic        er;
      int          due;
   } exp_t;

   exp_t        sb [$];
   logic [31:0] mem_m   [2][NMEM];
   logic [31:0] last_rd [2];
   int          lat     [2];

   dm_responder #(.NMEM(NMEM), .LATENCY(2)) u_dut_l2 (
      .clk(clk), .rst_n(rst_n),
      .req_i(req[0]), .we_i(we[0]), .addr_i(addr[0]), .wdata_i(wdata[0]), .be_i(be[0]),
      .ready_o(ready[0]), .done_o(done[0]), .rdata_o(rdata[0]), .err_o(err[0])
   );

   dm_responder #(.NMEM(NMEM), .LATENCY(0)) u_dut_l0 (
      .clk(clk), .rst_n(rst_n),
      .req_i(req[1]), .we_i(we[1]), .addr_i(addr[1]), .wdata_i(wdata[1]), .be_i(be[1]),
      .ready_o(ready[1]), .done_o(done[1]), .rdata_o(rdata[1]), .err_o(err[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, got, want, cyc);
      end
   endtask

   // Reference model: one transaction's effect on memory and on the response
   task automatic model(input int k, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] b,
                        output logic [31:0] rd, output logic er);
      int idx;
      idx = int'(a >> 2);
      if ((a % 4) != 0 || a >= 4 * NMEM) begin
         rd = 32'd0;
         er = 1'b1;
      end else if (w) begin
         for (int i = 0; i < 4; i++)
            if (b[i]) mem_m[k][idx][8*i +: 8] = d[8*i +: 8];
         rd = last_rd[k];
         er = 1'b0;
      end else begin
         rd = mem_m[k][idx];
         er = 1'b0;
      end
      last_rd[k] = rd;
   endtask

   // Present one request at a falling edge and wait for it to be accepted
   task automatic issue(input int k, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] b,
                        input bit keep, input bit abort);
      int   n;
      exp_t e;
      req[k] = 1'b1; we[k] = w; addr[k] = a; wdata[k] = d; be[k] = b;
      n = 0;
      while (!ready[k] && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!ready[k]) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout inst %0d: ready stayed 0, expected 1 within 100 cycles", k);
         req[k] = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      if (!abort) begin
         e.inst = k;
         e.due  = cyc + lat[k] + 1;
         model(k, w, a, d, b, e.rd, e.er);
         sb.push_back(e);
      end
      @(negedge clk);
      if (!keep) req[k] = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d completions outstanding, expected 0", sb.size());
         sb.delete();
      end
      @(negedge clk);
   endtask

   // Monitor: every done pulse must match the oldest expected completion
   always @(negedge clk) begin
      if (rst_n) begin
         for (int k = 0; k < 2; k++) begin
            if (done[k]) begin
               if (sb.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_done inst %0d: done=1 with no outstanding request, expected 0 (cycle %0d)", k, cyc);
               end else begin
                  exp_t e;
                  e = sb.pop_front();
                  chk("done_inst",  32'(k),     32'(e.inst));
                  chk("done_cycle", 32'(cyc),   32'(e.due));
                  chk("rdata",      rdata[k],   e.rd);
                  chk("err",        32'(err[k]), 32'(e.er));
               end
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] a;
      int          r;
      lat[0] = 2;
      lat[1] = 0;
      for (int k = 0; k < 2; k++) begin
         req[k] = 1'b0; we[k] = 1'b0; addr[k] = '0; wdata[k] = '0; be[k] = '0;
         last_rd[k] = 32'd0;
         for (int i = 0; i < NMEM; i++) mem_m[k][i] = 32'd0;
      end
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         chk("reset_ready", 32'(ready[k]), 32'd1);
         chk("reset_done",  32'(done[k]),  32'd0);
         chk("reset_rdata", rdata[k],      32'd0);
         chk("reset_err",   32'(err[k]),   32'd0);
      end
      rst_n = 1'b1;
      @(negedge clk);

      // Bring both memories to a known all-zero image, back to back
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < NMEM; i++)
            issue(k, 1'b1, 32'(4 * i), 32'd0, 4'hF, i != NMEM - 1, 1'b0);
         drain();
      end

      // Reset in the middle of a waiting store aborts it
      issue(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("midreset_ready", 32'(ready[0]), 32'd1);
      chk("midreset_done",  32'(done[0]),  32'd0);
      chk("midreset_rdata", rdata[0],      32'd0);
      last_rd[0] = 32'd0;
      last_rd[1] = 32'd0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      repeat (3) @(negedge clk);
      issue(0, 1'b0, 32'h10, 32'd0, 4'h0, 1'b0, 1'b0);
      drain();

      // Directed cases on the two-wait-state instance
      issue(0, 1'b1, 32'h8, 32'h11223344, 4'hF, 1'b0, 1'b0);
      issue(0, 1'b0, 32'h8, 32'd0, 4'h0, 1'b0, 1'b0);
      issue(0, 1'b1, 32'h8, 32'hAABBCCDD, 4'h5, 1'b0, 1'b0);
      issue(0, 1'b0, 32'h8, 32'd0, 4'h0, 1'b0, 1'b0);
      issue(0, 1'b1, 32'hC, 32'h55555555, 4'h0, 1'b0, 1'b0);
      issue(0, 1'b0, 32'hC, 32'd0, 4'h0, 1'b0, 1'b0);
      issue(0, 1'b1, 32'(4 * NMEM - 4), 32'hCAFEF00D, 4'hF, 1'b0, 1'b0);
      issue(0, 1'b0, 32'h6, 32'd0, 4'h0, 1'b0, 1'b0);
      issue(0, 1'b1, 32'(4 * NMEM), 32'h12345678, 4'hF, 1'b0, 1'b0);
      issue(0, 1'b0, 32'(4 * NMEM - 4), 32'd0, 4'h0, 1'b0, 1'b0);
      drain();

      // A request shown only while busy must never be accepted
      issue(0, 1'b0, 32'h8, 32'd0, 4'h0, 1'b0, 1'b0);
      req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h8; wdata[0] = 32'hFFFFFFFF; be[0] = 4'hF;
      @(negedge clk);
      req[0] = 1'b0;
      drain();
      repeat (4) @(negedge clk);
      issue(0, 1'b0, 32'h8, 32'd0, 4'h0, 1'b0, 1'b0);
      drain();

      // Zero wait states, request held high, alternating store/load to word 0
      for (int i = 0; i < 16; i++)
         issue(1, i[0] == 1'b0, 32'h0, $urandom, 4'hF, i != 15, 1'b0);
      drain();

      // Randomized traffic on both instances
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < 150; i++) begin
            r = $urandom_range(0, 9);
            if (r == 0)      a = 32'(4 * $urandom_range(0, NMEM - 1) + $urandom_range(1, 3));
            else if (r == 1) a = 32'(4 * NMEM) + ($urandom & 32'h0000FFFC);
            else             a = 32'(4 * $urandom_range(0, 15));
            issue(k, $urandom_range(0, 1) == 1, a, $urandom, 4'($urandom),
                  $urandom_range(0, 1) == 1, 1'b0);
            if (req[k] == 1'b0) repeat ($urandom_range(0, 2)) @(negedge clk);
         end
         req[k] = 1'b0;
         drain();
      end

      repeat (5) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
